uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ requesters, using round-robin arbitration.
- Captures the winning requester's byte and drives a one-cycle enable plus parallel data into the transmitter.
- Holds ownership until the transmitter reports frame completion.
- Sits between the producer blocks (command/status/debug sources) and the transmitter core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIT_NUM, 8, data bits per UART frame; must match the transmitter.
- TIMEOUT_CYCLES, 16384, watchdog limit in i_clk cycles; only used when UART_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_req  input  NUM_REQ  per-requester transmit request, level, held until granted.
- i_data  input  NUM_REQ*BIT_NUM  requester k's byte in bits [k*BIT_NUM +: BIT_NUM].
- o_grant  output  NUM_REQ  one-hot, one-cycle accept pulse; data captured this cycle.
- o_tx_en  output  1  one-cycle start pulse to the transmitter.
- o_tx_data  output  BIT_NUM  registered byte to the transmitter, stable until the next grant.
- i_tx_done  input  1  one-cycle pulse from the transmitter at end of the stop bit.
- o_busy  output  1  high while a frame is owned (WAIT_DONE state).
- o_owner  output  clog2(NUM_REQ)  index of the last granted requester.
- o_timeout  output  1  one-cycle watchdog abort pulse; tied 0 when the feature is compiled out.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state=IDLE.
  - o_grant=0, o_tx_en=0, o_tx_data=0, o_busy=0, o_owner=0, o_timeout=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the frame with no grant or pulse; the transmitter is reset separately.
- States: IDLE, WAIT_DONE.
- IDLE, when |i_req=1 at edge N:
  - winner = first set bit searching upward from (pointer+1) mod NUM_REQ.
  - At edge N: o_grant[winner]<=1, o_tx_en<=1, o_tx_data<=i_data slice of winner, o_owner<=winner, pointer<=winner, o_busy<=1, state<=WAIT_DONE.
  - Latency: request sampled at edge N, grant/enable visible in cycle N+1.
- IDLE with no requests: all pulses 0, state holds.
- WAIT_DONE:
  - o_grant and o_tx_en return to 0 after exactly one cycle.
  - i_tx_done while o_tx_en=1 (first WAIT_DONE cycle) is ignored.
  - Any later i_tx_done: state<=IDLE, o_busy<=0.
- Back-to-back timing:
  - done at edge D gives IDLE during D+1.
  - A pending request is sampled at edge D+1 and granted in cycle D+2.
  - Minimum one IDLE cycle between frames.
- Requester rules:
  - A requester must hold i_req and its data stable until its o_grant pulse.
  - Dropping i_req before grant withdraws the request; not an error.
  - After grant, the requester deasserts i_req, or keeps it high to queue the next byte (re-arbitrated fairly).
- Fairness: with all requesters continuously requesting, grant order is 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 frames.
- i_req changes during WAIT_DONE have no effect until IDLE.
- Single requester active: granted on every frame with no starvation stall.
- o_owner and o_tx_data hold their values after the frame until the next grant.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A 32-bit cycle counter clears at grant and increments in WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES-1 without a valid i_tx_done: state<=IDLE, o_busy<=0, one-cycle o_timeout pulse.
  - The pointer stays advanced, so the hung owner loses priority.
  - Simultaneous done and timeout at the same edge is treated as done; no o_timeout.
- Undefined: no counter is built, o_timeout is constant 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE, WAIT_DONE), shared with the transmitter's state constants.
  - default BIT_NUM=8.
  - the clog2 function.
- Sub-module rr_arbiter (combinational):
  - inputs: req vector, pointer.
  - outputs: one-hot grant and index.
  - reusable by a future RX-side dispatcher.
- The top module holds the FSM, data capture and watchdog.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_req=4'b1111 -> all outputs 0, no grant. Release -> cycle after sampling: o_grant=0001, o_tx_en=1, o_tx_data=i_data[7:0]=8'hA5.
- Round-robin: i_req=4'b1111 held, transmitter model gives done 10 cycles after enable -> grants 0,1,2,3,0 in order, bytes 8'h11,8'h22,8'h33,8'h44 on o_tx_data, one IDLE cycle between frames.
- Sparse and withdrawn requests:
  - i_req=4'b1010 after owner=1 -> next grant is requester 3, then 1.
  - Requester 2 raises and drops i_req within WAIT_DONE -> never granted.
- Spurious and boundary done:
  - i_tx_done pulsed in the o_tx_en cycle -> ignored, o_busy stays 1; real done 5 cycles later -> o_busy=0 next cycle.
  - New i_req arriving at the done edge -> grant two cycles later.
- Mid-frame reset: assert i_rst_n=0 while o_busy=1 -> next cycle all outputs 0 and pointer restarts; the first grant after release goes to the lowest-index requester.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): no done after grant -> o_timeout=1 exactly 20 cycles after grant, IDLE next, next pending requester granted. Rebuilt without the macro -> o_busy stays 1 for 1000 cycles, o_timeout never 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default frame width and clog2 helper.
// Used by the TX arbiter and the transmitter core.
package uart_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_DONE = 1'b1
   } state_t;

   localparam int DEF_BIT_NUM = 8;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 (mod N).
// Returns a one-hot grant and the matching index; all zero when nothing is requested.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   int   k;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      // i runs 1..N so the last candidate checked is the current pointer itself
      for (int i = 1; i <= N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ producers.
// Optional watchdog abort of a hung frame is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int BIT_NUM        = DEF_BIT_NUM,
   parameter int TIMEOUT_CYCLES = 16384
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [NUM_REQ*BIT_NUM-1:0]   i_data,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic                         o_tx_en,
   output logic [BIT_NUM-1:0]           o_tx_data,
   input  logic                         i_tx_done,
   output logic                         o_busy,
   output logic [clog2(NUM_REQ)-1:0]    o_owner,
   output logic                         o_timeout
);

   localparam int IDX_W = clog2(NUM_REQ);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               grant_now;
   logic               done_ok;
   logic               timeout_hit;
   logic               abort_now;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req (i_req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // a done coinciding with the start pulse belongs to a previous frame
   assign done_ok = i_tx_done && !o_tx_en;
   assign o_busy  = (state == WAIT_DONE);

`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0] wd_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wd_cnt <= '0;
      end else if (grant_now) begin
         wd_cnt <= '0;
      end else if (state == WAIT_DONE) begin
         wd_cnt <= wd_cnt + 32'd1;
      end
   end

   assign timeout_hit = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   // watchdog compiled out: the comparison is constant false for any legal limit
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_nxt = state;
      grant_now = 1'b0;
      abort_now = 1'b0;
      case (state)
         IDLE: begin
            if (|i_req) begin
               grant_now = 1'b1;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (done_ok) begin
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               abort_now = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         ptr       <= IDX_W'(NUM_REQ - 1);
         o_grant   <= '0;
         o_tx_en   <= 1'b0;
         o_tx_data <= '0;
         o_owner   <= '0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_grant   <= '0;
         o_tx_en   <= 1'b0;
         o_timeout <= abort_now;
         if (grant_now) begin
            o_grant   <= arb_gnt;
            o_tx_en   <= 1'b1;
            o_tx_data <= i_data[arb_idx*BIT_NUM +: BIT_NUM];
            o_owner   <= arb_idx;
            ptr       <= arb_idx;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, round-robin order, sparse/withdrawn requests,
// early and boundary done, mid-frame reset and the watchdog (both build variants).
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int BIT_NUM = 8;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req;
   logic [31:0]  data;
   logic [3:0]   grant;
   logic         tx_en;
   logic [7:0]   tx_data;
   logic         tx_done;
   logic         busy;
   logic [1:0]   owner;
   logic         timeout;

   int total;
   int bad;

   uart_tx_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .BIT_NUM        (BIT_NUM),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (req),
      .i_data    (data),
      .o_grant   (grant),
      .o_tx_en   (tx_en),
      .o_tx_data (tx_data),
      .i_tx_done (tx_done),
      .o_busy    (busy),
      .o_owner   (owner),
      .o_timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] e_grant, input logic e_en,
                          input logic [7:0] e_data, input logic e_busy, input logic [1:0] e_owner);
      chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
      chk({tag, ".tx_en"}, 32'(tx_en), 32'(e_en));
      chk({tag, ".tx_data"}, 32'(tx_data), 32'(e_data));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
      chk({tag, ".timeout"}, 32'(timeout), 32'd0);
   endtask

   // one done pulse after `wait_n` cycles, then the following IDLE cycle; ends in the next grant cycle
   task automatic finish_frame(input string tag, input int wait_n, input logic [7:0] e_data,
                               input logic [1:0] e_owner);
      tick(wait_n);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      chk_all({tag, ".idle"}, 4'b0000, 1'b0, e_data, 1'b0, e_owner);
      tick(1);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      req     = 4'b1111;
      data    = {8'h44, 8'h33, 8'h22, 8'hA5};
      tx_done = 1'b0;

      tick(3);
      chk_all("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      rst_n = 1'b1;
      tick(1);
      chk_all("first_grant", 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0);
      data = {8'h44, 8'h33, 8'h22, 8'h11};
      tick(1);
      chk_all("pulse_width", 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0);

      finish_frame("rr1", 8, 8'hA5, 2'd0);
      chk_all("rr_grant1", 4'b0010, 1'b1, 8'h22, 1'b1, 2'd1);
      finish_frame("rr2", 9, 8'h22, 2'd1);
      chk_all("rr_grant2", 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2);
      finish_frame("rr3", 9, 8'h33, 2'd2);
      chk_all("rr_grant3", 4'b1000, 1'b1, 8'h44, 1'b1, 2'd3);
      finish_frame("rr0", 9, 8'h44, 2'd3);
      chk_all("rr_grant0", 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);

      req = 4'b1010;
      finish_frame("sp_a", 4, 8'h11, 2'd0);
      chk_all("sparse_1", 4'b0010, 1'b1, 8'h22, 1'b1, 2'd1);
      tick(1);
      req = 4'b1110;
      tick(2);
      req = 4'b1010;
      finish_frame("sp_b", 2, 8'h22, 2'd1);
      chk_all("sparse_3", 4'b1000, 1'b1, 8'h44, 1'b1, 2'd3);
      finish_frame("sp_c", 4, 8'h44, 2'd3);
      chk_all("sparse_1b", 4'b0010, 1'b1, 8'h22, 1'b1, 2'd1);

      req     = 4'b0000;
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      chk_all("early_done", 4'b0000, 1'b0, 8'h22, 1'b1, 2'd1);
      tick(4);
      chk_all("still_busy", 4'b0000, 1'b0, 8'h22, 1'b1, 2'd1);
      tx_done = 1'b1;
      req     = 4'b0100;
      tick(1);
      tx_done = 1'b0;
      chk_all("done_edge_req", 4'b0000, 1'b0, 8'h22, 1'b0, 2'd1);
      tick(1);
      chk_all("late_grant", 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2);

      tick(2);
      req   = 4'b1010;
      rst_n = 1'b0;
      tick(1);
      chk_all("mid_reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      rst_n = 1'b1;
      tick(1);
      chk_all("post_reset", 4'b0010, 1'b1, 8'h22, 1'b1, 2'd1);

      req = 4'b1000;
`ifdef UART_ARB_TIMEOUT_EN
      for (int i = 0; i < 19; i++) begin
         tick(1);
         chk("wd_quiet", 32'(timeout), 32'd0);
         chk("wd_busy", 32'(busy), 32'd1);
      end
      tick(1);
      chk("wd_pulse", 32'(timeout), 32'd1);
      chk("wd_idle", 32'(busy), 32'd0);
      tick(1);
      chk_all("wd_next", 4'b1000, 1'b1, 8'h44, 1'b1, 2'd3);
`else
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         chk("no_wd_timeout", 32'(timeout), 32'd0);
         chk("no_wd_busy", 32'(busy), 32'd1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
